// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one 32-bit ALU between NREQ requesters
//
// Purpose: accepts one ALU operation at a time from NREQ requesters (round-robin),
// drives the external ALU from registered operands, holds the result/flags and
// returns them to the granted requester over a valid/ready response channel.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester request handshake (ready one-hot or zero)
//   req_a/req_b/req_ctrl       packed per-requester operands and ALU control
//   rsp_valid/rsp_ready        per-requester response handshake (valid one-hot or zero)
//   rsp_result/rsp_flags       shared response bus {N,Z,C,V}
//   alu_srca/alu_srcb/alu_ctrl to the ALU, always the operand registers
//   alu_result/alu_flag        from the ALU
//   busy                       high whenever not IDLE
//   op_count                   completed response handshakes, wrapping

module alu_arbiter #(
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*2-1:0]    req_ctrl,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_result,
    output logic [3:0]           rsp_flags,
    output logic [31:0]          alu_srca,
    output logic [31:0]          alu_srcb,
    output logic [1:0]           alu_ctrl,
    input  logic [31:0]          alu_result,
    input  logic [3:0]           alu_flag,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_last_grant;
    logic [ID_W-1:0]  r_cur_id;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;
    logic [1:0]       r_op_ctrl;
    logic [31:0]      r_result;
    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_op_count;

    int               w_idx;
    logic [ID_W-1:0]  w_cand;
    logic             w_grant_valid;
    logic [ID_W-1:0]  w_grant_id;
    logic [31:0]      w_sel_a;
    logic [31:0]      w_sel_b;
    logic [1:0]       w_sel_ctrl;
    logic             w_rsp_done;

    // Round-robin search: offsets 1..NREQ from the last grant, so the last
    // winner is considered only after every other requester.
    always_comb begin
        w_idx         = 0;
        w_cand        = '0;
        w_grant_valid = 1'b0;
        w_grant_id    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx  = (int'(r_last_grant) + k) % NREQ;
            w_cand = ID_W'(w_idx);
            if (!w_grant_valid && req_valid[w_cand]) begin
                w_grant_valid = 1'b1;
                w_grant_id    = w_cand;
            end
        end
    end

    // Payload mux of the winning requester and one-hot ready/valid decode.
    always_comb begin
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_sel_ctrl = '0;
        req_ready  = '0;
        rsp_valid  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == w_grant_id) begin
                w_sel_a    = req_a[32*i +: 32];
                w_sel_b    = req_b[32*i +: 32];
                w_sel_ctrl = req_ctrl[2*i +: 2];
                req_ready[i] = (r_state == S_IDLE) && w_grant_valid;
            end
            if (ID_W'(i) == r_cur_id) begin
                rsp_valid[i] = (r_state == S_RESP);
            end
        end
    end

    // Only the owner's rsp_ready completes the response; other bits are ignored.
    assign w_rsp_done = (r_state == S_RESP) && rsp_ready[r_cur_id];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= ID_W'(NREQ - 1);
            r_cur_id     <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_ctrl    <= '0;
            r_result     <= '0;
            r_flags      <= '0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_op_a       <= w_sel_a;
                        r_op_b       <= w_sel_b;
                        r_op_ctrl    <= w_sel_ctrl;
                        r_cur_id     <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result <= alu_result;
                    r_flags  <= alu_flag;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_done) begin
                        r_op_count <= r_op_count + CNT_W'(1);
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_srca   = r_op_a;
    assign alu_srcb   = r_op_b;
    assign alu_ctrl   = r_op_ctrl;
    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;
    assign busy       = (r_state != S_IDLE);
    assign op_count   = r_op_count;

endmodule
